// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, response FIFO to decoder.
// Optional misaligned-redirect trap via `FETCH_MISALIGN_TRAP_EN (adds HALT state and oFetchFault).
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    output logic        oMemReq,
    output logic [31:0] oMemAddr,
    input  logic        iMemReady,
    input  logic        iMemRspValid,
    input  logic [31:0] iMemRspData,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPc,
    output logic        oInstValid,
    output logic [31:0] oInst,
    output logic [31:0] oInstPc,
    input  logic        iDecReady
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        oFetchFault
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    localparam logic [0:0] S_RUN  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [0:0] S_HALT = 1'b1;
`endif

    logic [0:0]    r_state, w_state_nx;
    logic [31:0]   r_pc, w_pc_nx;
    logic [31:0]   r_rsp_pc, w_rsp_pc_nx;
    logic [CW-1:0] r_count, w_count_nx;
    logic [CW-1:0] r_outst, w_outst_nx;
    logic [CW-1:0] r_drop, w_drop_nx;
    logic [AW-1:0] r_wptr, w_wptr_nx;
    logic [AW-1:0] r_rptr, w_rptr_nx;
    logic [31:0]   r_data [FIFO_DEPTH];
    logic [31:0]   r_pcs  [FIFO_DEPTH];

    logic          w_run;
    logic          w_credit;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic          r_fault, w_fault_nx;
    logic          w_misalign;
    assign w_misalign  = (iRedirectPc[1:0] != 2'b00);
    assign oFetchFault = r_fault;
`else
    logic          w_unused_lsb;
    assign w_unused_lsb = ^iRedirectPc[1:0];
`endif

    // Credit: buffered plus in-flight never exceeds FIFO capacity, so pushes cannot overflow.
    assign w_run      = (r_state == S_RUN);
    assign w_credit   = (SW'(r_count) + SW'(r_outst)) < SW'(FIFO_DEPTH);
    assign oMemReq    = iRst && w_run && !iRedirect && w_credit;
    assign oMemAddr   = r_pc;
    assign w_accept   = oMemReq && iMemReady;
    assign w_push     = iMemRspValid && (r_drop == '0) && !iRedirect;
    assign oInstValid = (r_count != '0);
    assign w_pop      = oInstValid && iDecReady && !iRedirect;
    assign oInst      = oInstValid ? r_data[r_rptr] : 32'h0;
    assign oInstPc    = oInstValid ? r_pcs[r_rptr]  : 32'h0;
    assign w_redir_pc = {iRedirectPc[31:2], 2'b00};

    // Next-state: normal accept/response/pop bookkeeping, then redirect overrides.
    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_rsp_pc_nx = r_rsp_pc;
        w_count_nx  = r_count;
        w_outst_nx  = r_outst;
        w_drop_nx   = r_drop;
        w_wptr_nx   = r_wptr;
        w_rptr_nx   = r_rptr;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_fault_nx  = r_fault;
`endif

        w_outst_nx = r_outst + CW'(w_accept) - CW'(iMemRspValid);
        if (w_accept) begin
            w_pc_nx = r_pc + 32'd4;
        end
        if (iMemRspValid && (r_drop != '0)) begin
            w_drop_nx = r_drop - CW'(1);
        end
        if (w_push) begin
            w_wptr_nx   = r_wptr + AW'(1);
            w_rsp_pc_nx = r_rsp_pc + 32'd4;
        end
        if (w_pop) begin
            w_rptr_nx = r_rptr + AW'(1);
        end
        w_count_nx = r_count + CW'(w_push) - CW'(w_pop);

        if (iRedirect) begin
            w_count_nx  = '0;
            w_wptr_nx   = '0;
            w_rptr_nx   = '0;
            w_pc_nx     = w_redir_pc;
            w_rsp_pc_nx = w_redir_pc;
            w_drop_nx   = r_outst - CW'(iMemRspValid);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_misalign) begin
                w_state_nx = S_HALT;
                w_fault_nx = 1'b1;
            end else begin
                w_state_nx = S_RUN;
                w_fault_nx = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_count  <= '0;
            r_outst  <= '0;
            r_drop   <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_fault  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_rsp_pc <= w_rsp_pc_nx;
            r_count  <= w_count_nx;
            r_outst  <= w_outst_nx;
            r_drop   <= w_drop_nx;
            r_wptr   <= w_wptr_nx;
            r_rptr   <= w_rptr_nx;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_fault  <= w_fault_nx;
`endif
        end
    end

    // Buffer storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_data[r_wptr] <= iMemRspData;
            r_pcs[r_wptr]  <= r_rsp_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed stimulus, in-order memory model, decoder-side monitor.
module tb_inst_fetch_unit;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        oMemReq;
    logic [31:0] oMemAddr;
    logic        iMemReady;
    logic        iMemRspValid;
    logic [31:0] iMemRspData;
    logic        iRedirect;
    logic [31:0] iRedirectPc;
    logic        oInstValid;
    logic [31:0] oInst;
    logic [31:0] oInstPc;
    logic        iDecReady;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        oFetchFault;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_q[$];
    bit          stall = 1'b0;
    int          acc_cnt = 0;
    int          total = 0;
    int          bad = 0;

    inst_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .oMemReq      (oMemReq),
        .oMemAddr     (oMemAddr),
        .iMemReady    (iMemReady),
        .iMemRspValid (iMemRspValid),
        .iMemRspData  (iMemRspData),
        .iRedirect    (iRedirect),
        .iRedirectPc  (iRedirectPc),
        .oInstValid   (oInstValid),
        .oInst        (oInst),
        .oInstPc      (oInstPc),
        .iDecReady    (iDecReady)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .oFetchFault  (oFetchFault)
`endif
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        @(negedge iClk);
        iMemReady = 1'b0;
        iDecReady = 1'b1;
        repeat (8) @(negedge iClk);
        #2;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Memory: one response per cycle, in order, earliest the cycle after accept; data = addr ^ DEAD_0000.
    initial begin
        logic [31:0] a;
        iMemRspValid = 1'b0;
        iMemRspData  = 32'h0;
        forever begin
            @(negedge iClk);
            #1;
            if (!iRst) begin
                pend_q.delete();
                iMemRspValid = 1'b0;
                iMemRspData  = 32'h0;
            end else if (!stall && pend_q.size() > 0) begin
                a = pend_q.pop_front();
                iMemRspValid = 1'b1;
                iMemRspData  = a ^ 32'hDEAD_0000;
            end else begin
                iMemRspValid = 1'b0;
                iMemRspData  = 32'h0;
            end
            #1;
            if (iRst && oMemReq && iMemReady) begin
                pend_q.push_back(oMemAddr);
                acc_cnt++;
            end
        end
    end

    // Decoder-side monitor: every real pop is checked against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge iClk);
            #2;
            if (iRst && oInstValid && iDecReady && !iRedirect) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got pc %h want none", oInstPc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", oInstPc, e.pc);
                    chk("inst", oInst, e.inst);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRst        = 1'b0;
        iMemReady   = 1'b0;
        iRedirect   = 1'b0;
        iRedirectPc = 32'h0;
        iDecReady   = 1'b0;

        // Reset state
        repeat (2) @(negedge iClk);
        #2;
        chk("rst_memreq", 32'(oMemReq), 32'd0);
        chk("rst_memaddr", oMemAddr, 32'h0);
        chk("rst_instvalid", 32'(oInstValid), 32'd0);
        chk("rst_inst", oInst, 32'h0);
        chk("rst_instpc", oInstPc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_fault", 32'(oFetchFault), 32'd0);
`endif

        // Streaming fetch with decoder always ready
        expect_inst(32'h00, 32'hDEAD_0000);
        expect_inst(32'h04, 32'hDEAD_0004);
        expect_inst(32'h08, 32'hDEAD_0008);
        expect_inst(32'h0C, 32'hDEAD_000C);
        expect_inst(32'h10, 32'hDEAD_0010);
        expect_inst(32'h14, 32'hDEAD_0014);
        @(negedge iClk);
        iRst = 1'b1; iMemReady = 1'b1; iDecReady = 1'b1;
        #2;
        chk("first_req", 32'(oMemReq), 32'd1);
        chk("first_addr", oMemAddr, 32'h0);
        repeat (5) @(negedge iClk);
        drain();

        // Fill FIFO with decoder stalled, then release
        @(negedge iClk);
        iRst = 1'b0; iMemReady = 1'b0; iDecReady = 1'b0;
        @(negedge iClk);
        iRst = 1'b1; iMemReady = 1'b1;
        acc_cnt = 0;
        repeat (6) @(negedge iClk);
        #2;
        chk("full_memreq", 32'(oMemReq), 32'd0);
        chk("full_acc_cnt", 32'(acc_cnt), 32'd4);
        chk("full_valid", 32'(oInstValid), 32'd1);
        expect_inst(32'h00, 32'hDEAD_0000);
        expect_inst(32'h04, 32'hDEAD_0004);
        expect_inst(32'h08, 32'hDEAD_0008);
        expect_inst(32'h0C, 32'hDEAD_000C);
        expect_inst(32'h10, 32'hDEAD_0010);
        iDecReady = 1'b1;
        @(negedge iClk);
        #2;
        chk("resume_req", 32'(oMemReq), 32'd1);
        chk("resume_addr", oMemAddr, 32'h10);
        drain();

        // Redirect with two stale requests outstanding
        @(negedge iClk);
        stall = 1'b1; iMemReady = 1'b1; iDecReady = 1'b1;
        @(negedge iClk);
        @(negedge iClk);
        iRedirect = 1'b1; iRedirectPc = 32'h100;
        #2;
        chk("redir_no_req", 32'(oMemReq), 32'd0);
        expect_inst(32'h100, 32'hDEAD_0100);
        expect_inst(32'h104, 32'hDEAD_0104);
        @(negedge iClk);
        iRedirect = 1'b0; stall = 1'b0;
        #2;
        chk("redir_req", 32'(oMemReq), 32'd1);
        chk("redir_addr", oMemAddr, 32'h100);
        chk("redir_valid", 32'(oInstValid), 32'd0);
        @(negedge iClk);
        drain();

        // Redirect coincident with a response and an attempted pop
        @(negedge iClk);
        iDecReady = 1'b0; iMemReady = 1'b1;
        @(negedge iClk);
        @(negedge iClk);
        iRedirect = 1'b1; iRedirectPc = 32'h300; iDecReady = 1'b1;
        #2;
        chk("coinc_no_req", 32'(oMemReq), 32'd0);
        chk("coinc_valid_before", 32'(oInstValid), 32'd1);
        expect_inst(32'h300, 32'hDEAD_0300);
        @(negedge iClk);
        iRedirect = 1'b0;
        #2;
        chk("coinc_empty", 32'(oInstValid), 32'd0);
        chk("coinc_addr", oMemAddr, 32'h300);
        drain();

        // Misaligned redirect target
        @(negedge iClk);
        iRedirect = 1'b1; iRedirectPc = 32'h102; iMemReady = 1'b0;
        @(negedge iClk);
        iRedirect = 1'b0; iMemReady = 1'b1;
        #2;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", 32'(oFetchFault), 32'd1);
        chk("mis_halt_req", 32'(oMemReq), 32'd0);
        @(negedge iClk);
        #2;
        chk("mis_halt_req2", 32'(oMemReq), 32'd0);
        @(negedge iClk);
        iRedirect = 1'b1; iRedirectPc = 32'h200;
        @(negedge iClk);
        iRedirect = 1'b0;
        #2;
        chk("mis_fault_clr", 32'(oFetchFault), 32'd0);
        chk("mis_rec_req", 32'(oMemReq), 32'd1);
        chk("mis_rec_addr", oMemAddr, 32'h200);
        expect_inst(32'h200, 32'hDEAD_0200);
`else
        chk("mis_req", 32'(oMemReq), 32'd1);
        chk("mis_addr", oMemAddr, 32'h100);
        expect_inst(32'h100, 32'hDEAD_0100);
`endif
        drain();

        // Reset pulse with a full FIFO
        @(negedge iClk);
        iDecReady = 1'b0; iMemReady = 1'b1;
        repeat (6) @(negedge iClk);
        iRst = 1'b0;
        #2;
        chk("midrst_memreq", 32'(oMemReq), 32'd0);
        @(negedge iClk);
        iRst = 1'b1; iDecReady = 1'b1;
        #2;
        chk("midrst_valid", 32'(oInstValid), 32'd0);
        chk("midrst_req", 32'(oMemReq), 32'd1);
        chk("midrst_addr", oMemAddr, 32'h0);
        expect_inst(32'h00, 32'hDEAD_0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
